// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, coordinate typedefs and total-period helper.
// Latency: none (declarations only).
// Backpressure: none.
package vga_timing_pkg;

    // 640x480@60 defaults
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    typedef logic [9:0] coord_t;
    typedef logic [5:0] tile_t;

    // Full period of one axis: visible region plus all three blanking intervals.
    function automatic int unsigned timing_total(input int unsigned active,
                                                 input int unsigned fp,
                                                 input int unsigned sync,
                                                 input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enable-gated shift register of DEPTH stages, each WIDTH bits, reset to RST_VAL.
// Latency: DEPTH enabled ticks from din to dout.
// Backpressure: none; stages hold while en is low.
module vga_delay_line #(
    parameter int unsigned           DEPTH   = 2,
    parameter int unsigned           WIDTH   = 1,
    parameter logic [WIDTH-1:0]      RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [DEPTH];

    // Shift one position per enabled tick; reset loads every stage with the idle value.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= RST_VAL;
            end
        end else if (en) begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/vga_raster_gen.sv
// Raster scan counter pair with decoded logical/tile coordinates, syncs and line/frame pulses.
// Latency: decode is combinational from the counters; pulses are registered one clk after the wrap.
// Backpressure: none; pix_en gates counting. Optional macro VGA_SYNC_DELAY_EN delays hsync/vsync/active.
module vga_raster_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = DEF_H_ACTIVE,
    parameter int unsigned H_FP        = DEF_H_FP,
    parameter int unsigned H_SYNC      = DEF_H_SYNC,
    parameter int unsigned H_BP        = DEF_H_BP,
    parameter int unsigned V_ACTIVE    = DEF_V_ACTIVE,
    parameter int unsigned V_FP        = DEF_V_FP,
    parameter int unsigned V_SYNC      = DEF_V_SYNC,
    parameter int unsigned V_BP        = DEF_V_BP,
    parameter int unsigned SCALE_SHIFT = 2,
    parameter int unsigned TILE_SHIFT  = 3,
    parameter int unsigned SYNC_DELAY  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pix_en,
    output logic [9:0] xpos,
    output logic [9:0] ypos,
    output logic [5:0] xpellet,
    output logic [5:0] ypellet,
    output logic       active,
    output logic       hsync,
    output logic       vsync,
    output logic       line_start,
    output logic       frame_start
);

    localparam int unsigned H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;

    logic   act_raw;
    logic   hs_raw;
    logic   vs_raw;
    coord_t x_c;
    coord_t y_c;

    // Advance the scan position on each pixel tick and flag the line/frame wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt        <= '0;
            vcnt        <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (pix_en) begin
                if (hcnt == H_LAST) begin
                    hcnt       <= '0;
                    line_start <= 1'b1;
                    if (vcnt == V_LAST) begin
                        vcnt        <= '0;
                        frame_start <= 1'b1;
                    end else begin
                        vcnt <= vcnt + 1'b1;
                    end
                end else begin
                    hcnt <= hcnt + 1'b1;
                end
            end
        end
    end

    // Decode visibility, syncs and scaled coordinates from the counters; compares done at 32 bits.
    always_comb begin
        act_raw = (32'(hcnt) < H_ACTIVE) && (32'(vcnt) < V_ACTIVE);
        hs_raw  = !((32'(hcnt) >= H_ACTIVE + H_FP) && (32'(hcnt) < H_ACTIVE + H_FP + H_SYNC));
        vs_raw  = !((32'(vcnt) >= V_ACTIVE + V_FP) && (32'(vcnt) < V_ACTIVE + V_FP + V_SYNC));
        x_c     = act_raw ? coord_t'(hcnt >> SCALE_SHIFT) : '0;
        y_c     = act_raw ? coord_t'(vcnt >> SCALE_SHIFT) : '0;
    end

    assign xpos    = x_c;
    assign ypos    = y_c;
    assign xpellet = tile_t'(x_c >> TILE_SHIFT);
    assign ypellet = tile_t'(y_c >> TILE_SHIFT);

`ifdef VGA_SYNC_DELAY_EN
    // Syncs and active trail the coordinates so they line up with the registered pixel colour.
    vga_delay_line #(
        .DEPTH   (SYNC_DELAY),
        .WIDTH   (3),
        .RST_VAL (3'b110)
    ) u_sync_dly (
        .clk  (clk),
        .rst  (rst),
        .en   (pix_en),
        .din  ({hs_raw, vs_raw, act_raw}),
        .dout ({hsync, vsync, active})
    );
`else
    assign hsync  = hs_raw;
    assign vsync  = vs_raw;
    assign active = act_raw;
`endif

endmodule
